// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side serializer.
// Holds the FSM state encoding and the beat-counter width helper.
// No logic; imported by fifo_rd_ser.

package fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Counter must be able to represent 0..ratio, hence ratio+1 codes.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_ser.sv
// fifo_rd_ser: pops IN_W-bit words from a show-ahead FIFO and emits each as RATIO OUT_W-bit beats.
// Latency: first beat valid 1 cycle after the pop; back-to-back words run with no bubble.
// Backpressure: beat, last flag and counter hold while out_ready is low; the next pop waits for the last-beat accept.
// Build option FIFO_RD_SER_MSB_FIRST_EN: beats leave MSB first (default is LSB first).

module fifo_rd_ser
  import fifo_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (IN_W % OUT_W != 0) begin : g_bad_width
    $error("fifo_rd_ser: IN_W must be a multiple of OUT_W");
  end

  state_e            state_q, state_d;
  logic [IN_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              done;
  logic              busy;

  assign busy   = (state_q == ST_BUSY);
  assign accept = busy & out_ready;
  assign done   = accept & (cnt_q == LAST_CNT);

  // Pop when nothing is in flight, or the word in flight finishes this cycle.
  // Gated by rst_n so no pop leaks out while the block is held in reset.
  assign fifo_pop = rst_n & ~fifo_empty & ~flush & (~busy | done);

  assign out_valid = busy;
  assign out_last  = busy & (cnt_q == LAST_CNT);
`ifdef FIFO_RD_SER_MSB_FIRST_EN
  assign out_data  = sh_q[IN_W-1 -: OUT_W];
`else
  assign out_data  = sh_q[OUT_W-1:0];
`endif

  // Next state: flush wins, then reload on pop, then finish or advance one beat.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (fifo_pop) begin
      state_d = ST_BUSY;
      sh_d    = fifo_dout;
      cnt_d   = '0;
    end else if (done) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
`ifdef FIFO_RD_SER_MSB_FIRST_EN
      sh_d  = sh_q << OUT_W;
`else
      sh_d  = sh_q >> OUT_W;
`endif
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, shift register and beat counter; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/fifo_rd_ser.md
Name: fifo_rd_ser

Overview:
- Pop-side reader/serializer for the team's synchronous show-ahead FIFO (push/pop, full/empty, combinational d_out of head entry).
- Drains IN_W-bit words from the FIFO and emits each as RATIO = IN_W/OUT_W narrower beats on a valid/ready stream.
- Sits between a FIFO and a narrow downstream consumer (serial link, byte-lane packer).
- Registered output; zero-bubble back-to-back words.

Parameters:
- IN_W, 8, FIFO word width; must equal the FIFO WIDTH.
- OUT_W, 2, output beat width; IN_W % OUT_W == 0 required (elaboration error otherwise).
- RATIO (localparam), IN_W/OUT_W, beats per word; RATIO == 1 is legal (plain registered pop-to-stream).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- fifo_dout, input, IN_W, FIFO head word (valid when fifo_empty = 0).
- fifo_empty, input, 1, FIFO empty flag.
- fifo_pop, output, 1, pop strobe to FIFO; combinational.
- flush, input, 1, synchronous discard of the word in flight.
- out_data, output, OUT_W, current beat.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, downstream accept.
- out_last, output, 1, high on the final beat of each word.

Behaviour:
- Reset (async, rst_n = 0): out_valid = 0, out_data = 0, out_last = 0, beat_cnt = 0, shift register = 0, state = IDLE. fifo_pop = 0 while in reset.
- Internals: IN_W-bit shift register sh, beat counter beat_cnt of width $clog2(RATIO+1), 2-state FSM IDLE/BUSY.
- accept = out_valid & out_ready.
- done = accept & (beat_cnt == RATIO-1).
- fifo_pop = !fifo_empty & !flush & (state == IDLE | done).
- Never asserted when fifo_empty = 1.
- IDLE:
  - If fifo_pop: sh <= fifo_dout, beat_cnt <= 0, go to BUSY.
  - out_valid is 1 the next cycle, so pop-to-first-beat latency is 1 cycle.
- BUSY:
  - out_valid = 1. out_data = sh[OUT_W-1:0] (LSB first). out_last = (beat_cnt == RATIO-1).
  - accept & !done: sh >>= OUT_W, beat_cnt++.
  - done & fifo_pop: reload sh from fifo_dout, beat_cnt <= 0, stay in BUSY. No bubble between words.
  - done & !fifo_pop: go to IDLE, out_valid = 0 the next cycle.
  - out_valid = 1 & !out_ready: out_data, out_last and beat_cnt hold stable. Once asserted, out_valid does not drop until accepted or flushed.
- flush (priority over everything except reset):
  - Next cycle: state = IDLE, out_valid = 0, beat_cnt = 0.
  - fifo_pop = 0 in the flush cycle; the FIFO contents are untouched.
  - A beat accepted in the flush cycle is still counted as transferred downstream; the rest of that word is discarded.
- fifo_empty rising while BUSY: no effect until done.
- RATIO == 1: every beat has out_last = 1; full throughput of one word per cycle while out_ready = 1 and the FIFO is non-empty.
- Reset mid-word: the partial word is lost and no pop is issued. Any FIFO pointer effects are the FIFO's own reset responsibility.
- Throughput: one beat per cycle under continuous out_ready. Word rate = 1 per RATIO cycles.

Optional Feature:
- Macro: FIFO_RD_SER_MSB_FIRST_EN.
- Defined: beats are emitted MSB first. out_data = sh[IN_W-1 -: OUT_W], and sh shifts left by OUT_W on accept.
- Undefined (default): LSB first as described in Behaviour.
- All handshake timing, out_last and flush behaviour are identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - FSM state encodings ST_IDLE = 1'b0, ST_BUSY = 1'b1.
  - Width helper function returning the counter width for a given RATIO.
- No sub-module: the counter and shift register are inline.
- Verification wrapper fifo_ser_top instantiates the FIFO (DEPTH = 4, WIDTH = IN_W) feeding fifo_rd_ser.

Test Plan:
- Single word: IN_W = 8, OUT_W = 2, push 0xB4, out_ready = 1.
  - One fifo_pop pulse.
  - Beats 0,1,3,2 on consecutive cycles; out_last on the 4th beat only; then out_valid = 0.
- Back-to-back words: push 0x1B, 0xE4, out_ready = 1.
  - 8 contiguous valid beats: 3,2,1,0,0,1,2,3.
  - Second pop occurs in the same cycle as the first word's last beat; no gap.
- Backpressure: 0xB4 with out_ready toggling 1,0,0,1,...
  - out_data/out_last hold while out_ready = 0.
  - Exactly 4 beats are transferred; exactly 1 pop.
- Empty guard: FIFO empty for 10 cycles, then push 0xFF.
  - fifo_pop = 0 throughout the empty period; the first beat appears 1 cycle after the pop.
- Flush mid-word: 0xB4 with 2 beats accepted, then flush while 0xE4 is queued.
  - out_valid = 0 the next cycle.
  - The next word output is 0xE4 from beat 0; FIFO count is unchanged by the flush.
- Async reset mid-word: assert rst_n = 0 after 1 beat.
  - All outputs 0 immediately; after release, no pop until the FIFO is non-empty again.
- MSB-first build (run with FIFO_RD_SER_MSB_FIRST_EN): 0xB4 -> beats 2,3,1,0.
